// File: rtl/bist_march_gen.sv
// bist_march_gen: March C- sequencer for the SRAM BIST datapath.
//
// Sequence (D0 = BG_PATTERN, D1 = ~BG_PATTERN):
//   M0 up(w D0)  M1 up(r D0, w D1)  M2 up(r D1, w D0)
//   M3 down(r D0, w D1)  M4 down(r D1, w D0)  M5 up(r D0)
// The sequencer issues one SRAM op per cycle with no bubbles. Each read is followed one cycle
// later by exp_valid/exp_data. The comparator's cmp_eq is sampled in that cycle.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             begin a test (honoured only when idle or done)
//   mem_addr/we/re    SRAM address and strobes (read data returns next cycle)
//   mem_wdata         SRAM write data
//   exp_data/valid    expected read data for the comparator, and its valid flag
//   cmp_eq            comparator equality result
//   busy, done        test in progress / test finished (done held until restart or reset)
//   fail, fail_addr   sticky mismatch flag and address of the first mismatching read
//   fail_count        mismatch count, saturating at 255
//
// Optional feature: define BIST_STOP_ON_FAIL_EN to abort the test at the first mismatch.

module bist_march_gen #(
    parameter int unsigned              ADDR_WIDTH = 4,
    parameter int unsigned              DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]    BG_PATTERN = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] exp_data,
    output logic                  exp_valid,
    input  logic                  cmp_eq,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [7:0]            fail_count
);

    localparam logic [DATA_WIDTH-1:0] D0       = BG_PATTERN;
    localparam logic [DATA_WIDTH-1:0] D1       = ~BG_PATTERN;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

`ifdef BIST_STOP_ON_FAIL_EN
    localparam bit StopOnFail = 1'b1;
`else
    localparam bit StopOnFail = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                  state_q;
    logic [2:0]              elem_q;      // current march element, 0..5
    logic [ADDR_WIDTH-1:0]   exp_addr_q;  // address of the read now being compared

    logic [2:0]              nxt_elem;
    logic [ADDR_WIDTH-1:0]   nxt_addr;
    logic                    nxt_we;
    logic                    addr_done;
    logic                    elem_end;
    logic                    last_op;
    logic                    mismatch;

    function automatic logic [DATA_WIDTH-1:0] wr_data(input logic [2:0] e);
        return (e == 3'd1 || e == 3'd3) ? D1 : D0;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rd_data(input logic [2:0] e);
        return (e == 3'd2 || e == 3'd4) ? D1 : D0;
    endfunction

    function automatic logic is_down(input logic [2:0] e);
        return (e == 3'd3 || e == 3'd4);
    endfunction

    assign mismatch = exp_valid && !cmp_eq;

    // Next op: a write (or M5's lone read) finishes the current address.
    always_comb begin
        addr_done = mem_we || (elem_q == 3'd5);
        elem_end  = is_down(elem_q) ? (mem_addr == '0) : (mem_addr == ADDR_MAX);
        last_op   = addr_done && elem_end && (elem_q == 3'd5);
        nxt_elem  = elem_q;
        nxt_addr  = mem_addr;
        nxt_we    = 1'b1;
        if (!addr_done) begin
            nxt_we = 1'b1;
        end else if (!elem_end) begin
            nxt_addr = is_down(elem_q) ? mem_addr - 1'b1 : mem_addr + 1'b1;
            nxt_we   = (elem_q == 3'd0);
        end else begin
            // Elements M1..M5 all open with a read.
            nxt_elem = elem_q + 3'd1;
            nxt_addr = is_down(nxt_elem) ? ADDR_MAX : '0;
            nxt_we   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            elem_q     <= '0;
            exp_addr_q <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_wdata  <= '0;
            exp_data   <= '0;
            exp_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_count <= '0;
        end else begin
            exp_valid <= 1'b0;
            exp_data  <= '0;

            if (mismatch) begin
                fail <= 1'b1;
                if (!fail) fail_addr <= exp_addr_q;
                if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
            end

            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q    <= StRun;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        fail       <= 1'b0;
                        fail_addr  <= '0;
                        fail_count <= '0;
                        elem_q     <= '0;
                        mem_addr   <= '0;
                        mem_we     <= 1'b1;
                        mem_re     <= 1'b0;
                        mem_wdata  <= D0;
                    end
                end
                StRun: begin
                    if (StopOnFail && mismatch) begin
                        state_q   <= StDone;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        mem_addr  <= '0;
                        mem_we    <= 1'b0;
                        mem_re    <= 1'b0;
                        mem_wdata <= '0;
                    end else begin
                        if (mem_re) begin
                            exp_valid  <= 1'b1;
                            exp_data   <= rd_data(elem_q);
                            exp_addr_q <= mem_addr;
                        end
                        if (last_op) begin
                            state_q   <= StDrain;
                            mem_addr  <= '0;
                            mem_we    <= 1'b0;
                            mem_re    <= 1'b0;
                            mem_wdata <= '0;
                        end else begin
                            elem_q    <= nxt_elem;
                            mem_addr  <= nxt_addr;
                            mem_we    <= nxt_we;
                            mem_re    <= !nxt_we;
                            mem_wdata <= nxt_we ? wr_data(nxt_elem) : '0;
                        end
                    end
                end
                StDrain: begin
                    state_q <= StDone;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/bist_march_gen.md
Name: bist_march_gen

Overview:
- March C- sequencer for the SRAM BIST datapath. Drives SRAM address, write-enable, read-enable and write data.
- Presents expected read data, aligned to the SRAM's 1-cycle read latency, to bist_comparator. The comparator gets exp_data on one input and SRAM read data on the other.
- Samples the comparator's equality result to build pass/fail status, first-failing address and error count.

Parameters:
- ADDR_WIDTH, 4, SRAM address width; N = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, SRAM word width; matches the comparator width.
- BG_PATTERN, 8'h00, background value "0"; value "1" = ~BG_PATTERN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin test; sampled only in IDLE or DONE
- mem_addr  out  ADDR_WIDTH  SRAM address
- mem_we  out  1  SRAM write strobe
- mem_re  out  1  SRAM read strobe; data returns next cycle
- mem_wdata  out  DATA_WIDTH  SRAM write data
- exp_data  out  DATA_WIDTH  expected read data, to comparator
- exp_valid  out  1  exp_data and comparator result valid this cycle
- cmp_eq  in  1  comparator a_eq_b; sampled only when exp_valid=1
- busy  out  1  test in progress
- done  out  1  test finished; held until next start or rst
- fail  out  1  sticky; at least one mismatch seen
- fail_addr  out  ADDR_WIDTH  address of the first mismatch
- fail_count  out  8  mismatch count, saturates at 255

Behaviour:
- Reset: rst=1 at an edge sends the FSM to IDLE and clears all outputs to 0. This includes mid-test; no further SRAM ops are issued after the reset edge.
- States:
  - IDLE: start -> RUN.
  - RUN: executes elements M0..M5 -> DRAIN.
  - DRAIN: one compare cycle for the final read -> DONE.
  - DONE: start -> RUN.
- start while busy is ignored.
- Entering RUN clears fail, fail_addr, fail_count and done.
- March C- elements (D0=BG_PATTERN, D1=~BG_PATTERN):
  - M0 up(w D0)
  - M1 up(r D0, w D1)
  - M2 up(r D1, w D0)
  - M3 down(r D0, w D1)
  - M4 down(r D1, w D0)
  - M5 up(r D0)
- Up = address 0..N-1; down = N-1..0.
- All ops for one address complete before the address advances.
- One op per cycle, no bubbles:
  - Exactly one of mem_we/mem_re is high in each RUN cycle.
  - 10*N op cycles, 5*N reads.
- Timing from start sampled at edge k:
  - First op (M0 w addr 0) is issued in cycle k+1.
  - The last op is issued in cycle k+10N.
  - DRAIN is cycle k+10N+1.
  - done=1 and busy=0 from cycle k+10N+2.
- busy=1 throughout RUN and DRAIN.
- Read issued in cycle t: exp_valid=1 in cycle t+1, with exp_data = expected value for that read.
- Outside exp_valid: exp_data=0. Outside RUN: mem_addr, mem_wdata, mem_we, mem_re are all 0.
- On exp_valid && !cmp_eq:
  - fail <= 1.
  - fail_count increments, saturating at 255.
  - fail_addr loads the address of that read, only if fail was 0.
- Element boundaries and N=1 need no special cases: the address wraps to the element's start value and the next element begins the following cycle.

Optional Feature:
- Macro: BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch (exp_valid cycle t+1) aborts the test.
  - The op already issued in cycle t+1 completes.
  - From cycle t+2: no ops, exp_valid=0, busy=0, done=1.
  - fail_count=1.
- Undefined: the test always runs to completion and all mismatches are counted.

Test Plan:
- Fault-free 16x8 SRAM model, BG 00:
  - start -> 160 op cycles, 80 exp_valid pulses.
  - done at start+162; fail=0, fail_count=0.
- Address order:
  - M0/M1/M2/M5 addresses run 0..15.
  - M3/M4 addresses run 15..0.
  - M1 write data = 8'hFF.
  - exp_data = 8'hFF on M2 reads.
- Stuck-at-1 on bit 0 at address 5, BG 00 -> fail=1, fail_addr=5, fail_count=3 (M1, M3, M5 reads).
- Reset mid-test:
  - rst asserted at cycle 50 -> next cycle all outputs 0, FSM in IDLE.
  - A subsequent start completes normally.
- Protocol:
  - start pulses during busy are ignored.
  - start in DONE after a failing run clears fail/fail_count, reruns, done at +162.
- With BIST_STOP_ON_FAIL_EN and the address-5 fault -> done 2 cycles after the first mismatched read, fail_count=1, fail_addr=5.
